fc_score_engine: RTL and testbench

- Fully-connected output layer that produces the ten class scores consumed by the argmax classifier.
- Streams 784 pixels in, fetches one 10-wide weight row per pixel from an external weight ROM, and multiply-accumulates into ten signed score accumulators.
- When all pixels are accumulated, presents data_out_0..9 and pulses classfication_en for one cycle to the downstream classifier.

---
 rtl/fc_score_engine_pkg.sv | 35 +++
 rtl/fc_score_engine_if.sv | 58 +++++
 rtl/fc_score_engine_mac_lane.sv | 65 ++++++
 rtl/fc_score_engine.sv | 141 ++++++++++++++
 tb/tb_fc_score_engine.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fc_score_engine_pkg.sv
// ============================================================================
// Module : fc_pkg
// Brief  : Shared sizes, FSM state type and weight-row slicing helper for the
//          fully-connected score engine.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fc_pkg;

    localparam int WEIGHTS_DAPTH  = 784;
    localparam int WEIGHTS_COLUMN = 10;
    localparam int WEIGHTS_WIDTH  = 16;
    localparam int PIXEL_WIDTH    = 8;
    localparam int RESULT_WIDTH   = 32;
    localparam int ADDR_WIDTH     = 10;
    localparam int ROW_WIDTH      = WEIGHTS_COLUMN * WEIGHTS_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic signed [WEIGHTS_WIDTH-1:0] weight_col(
        input logic [ROW_WIDTH-1:0] row,
        input int unsigned          k
    );
        return row[k*WEIGHTS_WIDTH +: WEIGHTS_WIDTH];
    endfunction

endpackage

`default_nettype wire

// File: rtl/fc_score_engine_if.sv
// ============================================================================
// Module : fc_score_engine_if
// Brief  : Pixel stream, weight ROM and score result bundle of the engine.
//          overflow_flag exists only when FC_SAT_ACC_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fc_score_engine_if;
    import fc_pkg::*;

    logic                          start;
    logic [PIXEL_WIDTH-1:0]        pixel_in;
    logic                          pixel_valid;
    logic                          pixel_ready;
    logic [ADDR_WIDTH-1:0]         weights_addr;
    logic [ROW_WIDTH-1:0]          weights_data;
    logic signed [RESULT_WIDTH-1:0] data_out_0;
    logic signed [RESULT_WIDTH-1:0] data_out_1;
    logic signed [RESULT_WIDTH-1:0] data_out_2;
    logic signed [RESULT_WIDTH-1:0] data_out_3;
    logic signed [RESULT_WIDTH-1:0] data_out_4;
    logic signed [RESULT_WIDTH-1:0] data_out_5;
    logic signed [RESULT_WIDTH-1:0] data_out_6;
    logic signed [RESULT_WIDTH-1:0] data_out_7;
    logic signed [RESULT_WIDTH-1:0] data_out_8;
    logic signed [RESULT_WIDTH-1:0] data_out_9;
    logic                          classfication_en;
    logic                          busy;
`ifdef FC_SAT_ACC_EN
    logic                          overflow_flag;
`endif

    modport slave (
        input  start, pixel_in, pixel_valid, weights_data,
        output pixel_ready, weights_addr,
        output data_out_0, data_out_1, data_out_2, data_out_3, data_out_4,
        output data_out_5, data_out_6, data_out_7, data_out_8, data_out_9,
        output classfication_en, busy
`ifdef FC_SAT_ACC_EN
        , output overflow_flag
`endif
    );

    modport master (
        output start, pixel_in, pixel_valid, weights_data,
        input  pixel_ready, weights_addr,
        input  data_out_0, data_out_1, data_out_2, data_out_3, data_out_4,
        input  data_out_5, data_out_6, data_out_7, data_out_8, data_out_9,
        input  classfication_en, busy
`ifdef FC_SAT_ACC_EN
        , input overflow_flag
`endif
    );

endinterface

`default_nettype wire

// File: rtl/fc_score_engine_mac_lane.sv
// ============================================================================
// Module : mac_lane
// Brief  : One class accumulator: acc += weight * pixel. Wraps by default;
//          saturates and reports overflow when FC_SAT_ACC_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_lane
    import fc_pkg::*;
(
    input  wire logic                           clk,
    input  wire logic                           rst,
    input  wire logic                           i_clear,
    input  wire logic                           i_en,
    input  wire logic [PIXEL_WIDTH-1:0]         i_pixel,
    input  wire logic signed [WEIGHTS_WIDTH-1:0] i_weight,
    output logic signed [RESULT_WIDTH-1:0]      o_acc
`ifdef FC_SAT_ACC_EN
    , output logic                              o_ovf
`endif
);

    localparam int c_PROD_W = WEIGHTS_WIDTH + PIXEL_WIDTH + 1;

    logic signed [RESULT_WIDTH-1:0] r_acc;
    logic signed [c_PROD_W-1:0]     w_prod;
    logic signed [RESULT_WIDTH-1:0] w_sum;

    assign w_prod = c_PROD_W'(i_weight) * c_PROD_W'($signed({1'b0, i_pixel}));

`ifdef FC_SAT_ACC_EN
    localparam logic signed [RESULT_WIDTH-1:0] c_MAX = {1'b0, {(RESULT_WIDTH-1){1'b1}}};
    localparam logic signed [RESULT_WIDTH-1:0] c_MIN = {1'b1, {(RESULT_WIDTH-1){1'b0}}};

    logic signed [RESULT_WIDTH:0] w_wide;
    logic                         w_ovf;

    // One guard bit is enough: a 25-bit product cannot overflow twice.
    assign w_wide = (RESULT_WIDTH+1)'(r_acc) + (RESULT_WIDTH+1)'(w_prod);
    assign w_ovf  = w_wide[RESULT_WIDTH] ^ w_wide[RESULT_WIDTH-1];
    assign w_sum  = w_ovf ? (w_wide[RESULT_WIDTH] ? c_MIN : c_MAX)
                          : w_wide[RESULT_WIDTH-1:0];
    assign o_ovf  = i_en & w_ovf;
`else
    assign w_sum  = r_acc + RESULT_WIDTH'(w_prod);
`endif

    // o_acc is the value the lane will hold after this edge, so the top can
    // capture the final MAC in the same cycle it happens.
    assign o_acc = i_en ? w_sum : r_acc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else begin
            r_acc <= o_acc;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fc_score_engine.sv
// ============================================================================
// Module : fc_score_engine
// Brief  : Streams 784 pixels against a 10-wide weight ROM and produces ten
//          signed class scores. Optional FC_SAT_ACC_EN enables saturation.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_score_engine
    import fc_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst,
    fc_score_engine_if.slave   bus
);

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [ADDR_WIDTH-1:0]          r_pixel_cnt;
    logic [PIXEL_WIDTH-1:0]         r_pixel;
    logic                           r_mac_vld;
    logic                           w_handshake;
    logic                           w_start_ok;
    logic                           w_last;
    logic signed [RESULT_WIDTH-1:0] r_data_out [WEIGHTS_COLUMN];
    logic signed [RESULT_WIDTH-1:0] w_acc_nxt  [WEIGHTS_COLUMN];
`ifdef FC_SAT_ACC_EN
    logic [WEIGHTS_COLUMN-1:0]      w_lane_ovf;
    logic                           r_overflow;
`endif

    assign w_start_ok  = bus.start && ((r_state == IDLE) || (r_state == DONE));
    assign w_handshake = bus.pixel_valid && (r_state == LOAD);
    assign w_last      = (r_pixel_cnt == ADDR_WIDTH'(WEIGHTS_DAPTH - 1));

    assign bus.weights_addr = (r_state == LOAD) ? r_pixel_cnt : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt          = r_state;
        bus.pixel_ready      = 1'b0;
        bus.busy             = 1'b0;
        bus.classfication_en = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) w_state_nxt = LOAD;
            end
            LOAD: begin
                bus.pixel_ready = 1'b1;
                bus.busy        = 1'b1;
                if (w_handshake && w_last) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                bus.busy    = 1'b1;
                w_state_nxt = DONE;
            end
            DONE: begin
                bus.classfication_en = 1'b1;
                w_state_nxt          = bus.start ? LOAD : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The ROM row for an accepted pixel arrives one cycle later, so the pixel
    // and its valid flag are delayed to line up with weights_data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pixel_cnt <= '0;
            r_pixel     <= '0;
            r_mac_vld   <= 1'b0;
        end else begin
            r_mac_vld <= w_handshake;
            if (w_handshake) begin
                r_pixel     <= bus.pixel_in;
                r_pixel_cnt <= r_pixel_cnt + ADDR_WIDTH'(1);
            end else if (w_start_ok) begin
                r_pixel_cnt <= '0;
            end
        end
    end

    for (genvar k = 0; k < WEIGHTS_COLUMN; k++) begin : g_lane
        mac_lane u_lane (
            .clk      (clk),
            .rst      (rst),
            .i_clear  (w_start_ok),
            .i_en     (r_mac_vld),
            .i_pixel  (r_pixel),
            .i_weight (weight_col(bus.weights_data, k)),
            .o_acc    (w_acc_nxt[k])
`ifdef FC_SAT_ACC_EN
            , .o_ovf  (w_lane_ovf[k])
`endif
        );
    end

    // DRAIN always carries the final MAC, captured here via the lane's next value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < WEIGHTS_COLUMN; k++) r_data_out[k] <= '0;
        end else if (r_state == DRAIN) begin
            for (int k = 0; k < WEIGHTS_COLUMN; k++) r_data_out[k] <= w_acc_nxt[k];
        end
    end

`ifdef FC_SAT_ACC_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_start_ok) begin
            r_overflow <= 1'b0;
        end else if (|w_lane_ovf) begin
            r_overflow <= 1'b1;
        end
    end

    assign bus.overflow_flag = r_overflow;
`endif

    assign bus.data_out_0 = r_data_out[0];
    assign bus.data_out_1 = r_data_out[1];
    assign bus.data_out_2 = r_data_out[2];
    assign bus.data_out_3 = r_data_out[3];
    assign bus.data_out_4 = r_data_out[4];
    assign bus.data_out_5 = r_data_out[5];
    assign bus.data_out_6 = r_data_out[6];
    assign bus.data_out_7 = r_data_out[7];
    assign bus.data_out_8 = r_data_out[8];
    assign bus.data_out_9 = r_data_out[9];

endmodule

`default_nettype wire

// File: tb/tb_fc_score_engine.sv
// ============================================================================
// Module : tb_fc_score_engine
// Brief  : Scoreboard bench for fc_score_engine with a ROM model and a plain
//          arithmetic reference; follows FC_SAT_ACC_EN when defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fc_score_engine;
    import fc_pkg::*;

    typedef struct {
        logic [9:0][31:0] s;
        logic             ovf;
        int               exp_cyc;
    } exp_t;

    localparam longint c_MAXV = 64'sd2147483647;
    localparam longint c_MINV = -c_MAXV - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]           pix [WEIGHTS_DAPTH];
    logic [ROW_WIDTH-1:0] rom [WEIGHTS_DAPTH];
    exp_t                 sb [$];
    exp_t                 me;

    fc_score_engine_if bus();

    fc_score_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Weight ROM with one cycle of read latency.
    always @(posedge clk)
        bus.weights_data <= (int'(bus.weights_addr) < WEIGHTS_DAPTH) ? rom[bus.weights_addr] : '0;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    function automatic logic [31:0] dout(input int k);
        case (k)
            0: return bus.data_out_0;
            1: return bus.data_out_1;
            2: return bus.data_out_2;
            3: return bus.data_out_3;
            4: return bus.data_out_4;
            5: return bus.data_out_5;
            6: return bus.data_out_6;
            7: return bus.data_out_7;
            8: return bus.data_out_8;
            default: return bus.data_out_9;
        endcase
    endfunction

    // Score_k = sum over pixels of pixel * weight_k, wrapped or clamped.
    function automatic exp_t model();
        exp_t   e;
        longint acc [10];
        longint p;
        e.ovf = 1'b0;
        e.exp_cyc = 0;
        for (int k = 0; k < 10; k++) acc[k] = 0;
        for (int i = 0; i < WEIGHTS_DAPTH; i++) begin
            for (int k = 0; k < 10; k++) begin
                p = longint'(pix[i]) * longint'($signed(rom[i][k*16 +: 16]));
                acc[k] = acc[k] + p;
`ifdef FC_SAT_ACC_EN
                if (acc[k] > c_MAXV) begin acc[k] = c_MAXV; e.ovf = 1'b1; end
                if (acc[k] < c_MINV) begin acc[k] = c_MINV; e.ovf = 1'b1; end
`endif
            end
        end
        for (int k = 0; k < 10; k++) e.s[k] = acc[k][31:0];
        return e;
    endfunction

    function automatic logic [ROW_WIDTH-1:0] row_fill(input logic [15:0] w);
        logic [ROW_WIDTH-1:0] r;
        for (int k = 0; k < 10; k++) r[k*16 +: 16] = w;
        return r;
    endfunction

    function automatic logic [ROW_WIDTH-1:0] rand_row();
        logic [ROW_WIDTH-1:0] r;
        for (int k = 0; k < 10; k++) r[k*16 +: 16] = 16'($urandom);
        return r;
    endfunction

    task automatic fill_const(input logic [7:0] p, input logic [15:0] w);
        for (int i = 0; i < WEIGHTS_DAPTH; i++) begin
            pix[i] = p;
            rom[i] = row_fill(w);
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < WEIGHTS_DAPTH; i++) begin
            pix[i] = 8'($urandom);
            rom[i] = rand_row();
        end
    endtask

    task automatic check_reset_state();
        chk("rst_pixel_ready", 64'(bus.pixel_ready), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_class_en", 64'(bus.classfication_en), 64'd0);
        chk("rst_weights_addr", 64'(bus.weights_addr), 64'd0);
        for (int k = 0; k < 10; k++)
            chk($sformatf("rst_data_out_%0d", k), 64'(dout(k)), 64'd0);
`ifdef FC_SAT_ACC_EN
        chk("rst_overflow_flag", 64'(bus.overflow_flag), 64'd0);
`endif
    endtask

    // mode: 0 = valid held high, 1 = strict 1-0-1 toggle, 2 = random gaps.
    task automatic run_image(input int mode, input bit start_mid, input int abort_at, input bit b2b);
        exp_t e;
        int   idx = 0;
        int   n = 0;
        int   w;
        bit   v;
        bit   seen = 1'b0;
        e = model();
        if (!b2b) @(negedge clk);
        e.exp_cyc = (mode == 0) ? cyc + 786 : 0;
        if (abort_at < 0) sb.push_back(e);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ready_after_start", 64'(bus.pixel_ready), 64'd1);
        chk("busy_after_start", 64'(bus.busy), 64'd1);
        while (idx < WEIGHTS_DAPTH && n < 20000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (n % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            bus.start       = start_mid && (n == 300);
            bus.pixel_valid = v;
            bus.pixel_in    = v ? pix[idx] : 8'($urandom);
            if (v && bus.pixel_ready) idx++;
            if (abort_at >= 0 && idx == abort_at) break;
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        if (abort_at >= 0 && idx == abort_at) begin
            bus.pixel_valid = 1'b0;
            rst = 1'b0;
            repeat (2) @(negedge clk);
            check_reset_state();
            rst = 1'b1;
            return;
        end
        if (idx < WEIGHTS_DAPTH) chk("feed_timeout", 64'(idx), 64'(WEIGHTS_DAPTH));
        // Junk offered while not ready must never be consumed.
        bus.pixel_valid = 1'b1;
        bus.pixel_in    = 8'($urandom);
        for (w = 0; w < 50; w++) begin
            @(negedge clk);
            if (bus.classfication_en) begin
                seen = 1'b1;
                break;
            end
        end
        bus.pixel_valid = 1'b0;
        if (!seen) chk("pulse_timeout", 64'd0, 64'd1);
    endtask

    always @(negedge clk) begin
        if (rst && bus.classfication_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 64'd1, 64'd0);
            end else begin
                me = sb.pop_front();
                for (int k = 0; k < 10; k++)
                    chk($sformatf("data_out_%0d", k), 64'(dout(k)), 64'(me.s[k]));
                chk("busy_at_pulse", 64'(bus.busy), 64'd0);
                if (me.exp_cyc != 0) chk("latency", 64'(cyc), 64'(me.exp_cyc));
`ifdef FC_SAT_ACC_EN
                chk("overflow_flag", 64'(bus.overflow_flag), 64'(me.ovf));
`endif
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bus.start       = 1'b0;
        bus.pixel_valid = 1'b0;
        bus.pixel_in    = '0;
        rst             = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        rst = 1'b1;

        fill_const(8'd1, 16'd1);
        run_image(0, 1'b0, -1, 1'b0);

        fill_rand();
        for (int i = 0; i < WEIGHTS_DAPTH; i++) pix[i] = 8'd0;
        pix[0] = 8'd255;
        for (int k = 0; k < 10; k++) rom[0][k*16 +: 16] = 16'(-(k + 1));
        run_image(2, 1'b0, -1, 1'b0);

        fill_rand();
        for (int i = 0; i < WEIGHTS_DAPTH; i++) begin
            pix[i] = 8'd2;
            rom[i][3*16 +: 16] = 16'd3;
        end
        run_image(1, 1'b0, -1, 1'b0);

        fill_const(8'd1, 16'd1);
        run_image(0, 1'b0, 400, 1'b0);
        run_image(0, 1'b0, -1, 1'b0);

        fill_const(8'd255, 16'd32767);
        run_image(0, 1'b0, -1, 1'b0);

        fill_rand();
        run_image(2, 1'b1, -1, 1'b0);

        fill_rand();
        run_image(0, 1'b0, -1, 1'b0);
        fill_rand();
        run_image(0, 1'b0, -1, 1'b1);

        for (int t = 0; t < 3; t++) begin
            fill_rand();
            run_image(int'($urandom_range(0, 2)), 1'b0, -1, 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
